banco_de_registradores_param: RTL and testbench
===============================================

// Module: banco_de_registradores_param
// PURPOSE
//   Parametrised multi-read-port register file for the MIPS datapath.
//   Provides N_READ asynchronous read ports, one synchronous write port,
//   optional write-to-read bypass, and a hardwired-zero register 0.
//   Includes a sequential clear engine that sweeps all entries to zero,
//   and a registered board-debug read port.
//   Sits between decode (rs/rt addressing) and writeback (rd/data).
// PARAMETERS
//   DATA_W  32  word width in bits
//   ADDR_W  5   address width; DEPTH = 2**ADDR_W entries
//   N_READ  2   number of asynchronous read ports (>=1)
//   BYPASS  1   1: same-cycle write data forwarded to matching read ports
// PORTS
//   brp_in_clk        in   1                clock, all state on rising edge
//   brp_in_rst_n      in   1                async reset, active low
//   brp_in_raddr      in   N_READ*ADDR_W    read addresses, port i at [i*ADDR_W +: ADDR_W]
//   brp_out_rdata     out  N_READ*DATA_W    read data, port i at [i*DATA_W +: DATA_W]
//   brp_in_we         in   1                write enable
//   brp_in_waddr      in   ADDR_W           write address
//   brp_in_wdata      in   DATA_W           write data
//   brp_in_clr_req    in   1                start full clear sweep (sampled in IDLE)
//   brp_out_busy      out  1                1 while clear sweep in progress
//   brp_out_clr_done  out  1                one-cycle pulse when sweep completes
//   brp_out_wr_err    out  1                one-cycle pulse: write dropped
//   brp_in_dbg_sel    in   ADDR_W           board debug register select
//   brp_out_dbg_data  out  DATA_W           board debug data, registered
// BEHAVIOUR
//   Reset (brp_in_rst_n=0, async): all entries 0, state IDLE, sweep counter 0,
//     busy=0, clr_done=0, wr_err=0, dbg_data=0. Held while low.
//   Entry 0: always reads 0; writes to address 0 have no effect, no wr_err.
//   FSM states: IDLE, CLEAR, DONE.
//     IDLE -> CLEAR when clr_req=1 at a rising edge; counter <= 0.
//     CLEAR: each cycle mem[counter] <= 0, counter++; at counter==DEPTH-1
//       -> DONE. Sweep takes exactly DEPTH cycles in CLEAR.
//     DONE: clr_done=1 for this one cycle; -> IDLE unconditionally.
//     busy=1 in CLEAR and DONE, else 0. clr_req outside IDLE is ignored.
//   Write: in IDLE with we=1 and clr_req=0, mem[waddr] <= wdata at the edge.
//     we=1 in CLEAR/DONE, or we=1 together with clr_req=1 in IDLE: write
//     dropped, wr_err=1 on the following cycle (registered pulse).
//   Read: combinational, zero latency, all ports independent, any ports may
//     share an address.
//     busy=1: all read ports return 0.
//     BYPASS=1, IDLE, we=1, clr_req=0, raddr==waddr!=0: return wdata.
//     Otherwise return mem[raddr] (0 for raddr==0).
//   Debug: dbg_data <= mem[dbg_sel] each edge (0 for sel 0); no bypass, so it
//     shows the value stored before that edge; 1-cycle latency; reads 0
//     during sweep.
//   Widths: no arithmetic on data; counter is ADDR_W bits; the DEPTH-1
//     terminal compare prevents wrap.
//   Reset mid-sweep: returns to IDLE with all entries 0; no clr_done pulse.
// TESTING
//   1. Reset, write 0xDEADBEEF to r5, next cycle raddr0=5 -> rdata0=0xDEADBEEF;
//      raddr1=5 -> same value on port 1.
//   2. BYPASS=1: we=1, waddr=7, wdata=0x12345678, raddr0=7 same cycle ->
//      rdata0=0x12345678 before the edge; BYPASS=0 -> old value 0.
//   3. Write 0xFFFFFFFF to r0, read r0 -> 0; wr_err stays 0.
//   4. Fill r1..r31, pulse clr_req -> busy=1 for 33 cycles (32 CLEAR + DONE),
//      clr_done pulses once, then all reads 0 and busy=0.
//   5. we=1 to r3 during CLEAR -> wr_err pulse next cycle; r3 reads 0 after
//      the sweep. we with clr_req in IDLE -> write dropped, wr_err=1.
//   6. Drop rst_n mid-sweep at counter=10 -> busy=0 immediately, no clr_done;
//      dbg_sel=4 after a write to r4 -> dbg_data updates one edge later.

Source files
------------

// File: rtl/banco_de_registradores_param.sv
// Parametrised MIPS register file: N_READ combinational read ports, one write port,
// optional write-to-read bypass, hardwired-zero r0, sequential clear sweep and debug port.
module banco_de_registradores_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_READ = 2,
  parameter int BYPASS = 1
) (
  input  logic                       brp_in_clk,
  input  logic                       brp_in_rst_n,
  input  logic [N_READ*ADDR_W-1:0]   brp_in_raddr,
  output logic [N_READ*DATA_W-1:0]   brp_out_rdata,
  input  logic                       brp_in_we,
  input  logic [ADDR_W-1:0]          brp_in_waddr,
  input  logic [DATA_W-1:0]          brp_in_wdata,
  input  logic                       brp_in_clr_req,
  output logic                       brp_out_busy,
  output logic                       brp_out_clr_done,
  output logic                       brp_out_wr_err,
  input  logic [ADDR_W-1:0]          brp_in_dbg_sel,
  output logic [DATA_W-1:0]          brp_out_dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic [1:0]        state_r;
  logic [1:0]        state_nx_s;
  logic [ADDR_W-1:0] cnt_r;
  logic              busy_s;
  logic              sweep_s;
  logic              wr_ok_s;
  logic              wr_drop_s;
  logic              wr_err_r;
  logic [DATA_W-1:0] dbg_r;

  // Entry 0 is not stored at all; it is hardwired to zero on every read path.
  logic [DATA_W-1:0] mem_r [1:DEPTH-1];

  function automatic logic [DATA_W-1:0] read_entry(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    if (addr == ADDR_ZERO) begin
      val = DATA_ZERO;
    end else begin
      val = mem_r[addr];
    end
    return val;
  endfunction

  // Control decode: sweep activity, accepted writes and dropped writes.
  always_comb begin
    sweep_s   = (state_r == ST_CLEAR);
    busy_s    = (state_r == ST_CLEAR) || (state_r == ST_DONE);
    wr_ok_s   = (state_r == ST_IDLE) && brp_in_we && !brp_in_clr_req &&
                (brp_in_waddr != ADDR_ZERO);
    wr_drop_s = brp_in_we && (brp_in_waddr != ADDR_ZERO) &&
                ((state_r != ST_IDLE) || brp_in_clr_req);
  end

  // Clear-sweep next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (brp_in_clr_req) begin
          state_nx_s = ST_CLEAR;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (cnt_r == CNT_LAST) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_CLEAR;
        end
      end
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // State register and sweep counter; the counter holds at its terminal value.
  always_ff @(posedge brp_in_clk or negedge brp_in_rst_n) begin
    if (!brp_in_rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= ADDR_ZERO;
    end else begin
      state_r <= state_nx_s;
      if ((state_r == ST_IDLE) && brp_in_clr_req) begin
        cnt_r <= ADDR_ZERO;
      end else if (sweep_s && (cnt_r != CNT_LAST)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  genvar e;
  generate
    for (e = 1; e < DEPTH; e++) begin : g_entry
      // Storage for entry e: cleared by the sweep, otherwise loaded by an accepted write.
      always_ff @(posedge brp_in_clk or negedge brp_in_rst_n) begin
        if (!brp_in_rst_n) begin
          mem_r[e] <= DATA_ZERO;
        end else if (sweep_s && (cnt_r == ADDR_W'(e))) begin
          mem_r[e] <= DATA_ZERO;
        end else if (wr_ok_s && (brp_in_waddr == ADDR_W'(e))) begin
          mem_r[e] <= brp_in_wdata;
        end else begin
          mem_r[e] <= mem_r[e];
        end
      end
    end
  endgenerate

  genvar p;
  generate
    for (p = 0; p < N_READ; p++) begin : g_rport
      logic [ADDR_W-1:0] raddr_s;
      assign raddr_s = brp_in_raddr[p*ADDR_W +: ADDR_W];

      // Read port p: blanked while busy, forwarded from the write port on a hit.
      always_comb begin
        if (busy_s) begin
          brp_out_rdata[p*DATA_W +: DATA_W] = DATA_ZERO;
        end else if ((BYPASS != 0) && wr_ok_s && (raddr_s == brp_in_waddr)) begin
          brp_out_rdata[p*DATA_W +: DATA_W] = brp_in_wdata;
        end else begin
          brp_out_rdata[p*DATA_W +: DATA_W] = read_entry(raddr_s);
        end
      end
    end
  endgenerate

  // Registered write-error pulse and debug read (stored value, never bypassed).
  always_ff @(posedge brp_in_clk or negedge brp_in_rst_n) begin
    if (!brp_in_rst_n) begin
      wr_err_r <= 1'b0;
      dbg_r    <= DATA_ZERO;
    end else begin
      wr_err_r <= wr_drop_s;
      if (busy_s) begin
        dbg_r <= DATA_ZERO;
      end else begin
        dbg_r <= read_entry(brp_in_dbg_sel);
      end
    end
  end

  assign brp_out_busy     = busy_s;
  assign brp_out_clr_done = (state_r == ST_DONE);
  assign brp_out_wr_err   = wr_err_r;
  assign brp_out_dbg_data = dbg_r;

endmodule

// File: tb/tb_banco_de_registradores_param.sv
// Self-checking bench: directed vector table, clear/reset sequences and random traffic
// checked against a behavioural register-file model (one BYPASS=1 and one BYPASS=0 instance).
module tb_banco_de_registradores_param;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2*AW-1:0] raddr;
  logic [2*DW-1:0] rdata_a, rdata_b;
  logic          we, clr_req;
  logic [AW-1:0] waddr, dbg_sel;
  logic [DW-1:0] wdata, dbg_a, dbg_b;
  logic          busy_a, busy_b, done_a, done_b, err_a, err_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  banco_de_registradores_param #(.DATA_W(DW), .ADDR_W(AW), .N_READ(2), .BYPASS(1)) dut_a (
    .brp_in_clk(clk), .brp_in_rst_n(rst_n), .brp_in_raddr(raddr), .brp_out_rdata(rdata_a),
    .brp_in_we(we), .brp_in_waddr(waddr), .brp_in_wdata(wdata), .brp_in_clr_req(clr_req),
    .brp_out_busy(busy_a), .brp_out_clr_done(done_a), .brp_out_wr_err(err_a),
    .brp_in_dbg_sel(dbg_sel), .brp_out_dbg_data(dbg_a));

  banco_de_registradores_param #(.DATA_W(DW), .ADDR_W(AW), .N_READ(2), .BYPASS(0)) dut_b (
    .brp_in_clk(clk), .brp_in_rst_n(rst_n), .brp_in_raddr(raddr), .brp_out_rdata(rdata_b),
    .brp_in_we(we), .brp_in_waddr(waddr), .brp_in_wdata(wdata), .brp_in_clr_req(clr_req),
    .brp_out_busy(busy_b), .brp_out_clr_done(done_b), .brp_out_wr_err(err_b),
    .brp_in_dbg_sel(dbg_sel), .brp_out_dbg_data(dbg_b));

  // Reference model: register contents plus the number of busy cycles still to come.
  logic [DW-1:0] mem_m [DEPTH];
  int            clr_left;
  logic          err_m;
  logic [DW-1:0] dbg_m;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    clr_left = 0;
    err_m = 1'b0;
    dbg_m = '0;
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (clr_left > 0) return '0;
    if (byp && we && !clr_req && a == waddr && a != 5'd0) return wdata;
    return mem_m[a];
  endfunction

  task automatic model_edge();
    logic          n_err;
    logic [DW-1:0] n_dbg;
    n_err = we && (waddr != 5'd0) && (clr_left > 0 || clr_req);
    n_dbg = (clr_left > 0) ? 32'd0 : mem_m[dbg_sel];
    if (clr_left > 0) begin
      clr_left = clr_left - 1;
    end else if (clr_req) begin
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      clr_left = DEPTH + 1;
    end else if (we && waddr != 5'd0) begin
      mem_m[waddr] = wdata;
    end
    err_m = n_err;
    dbg_m = n_dbg;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  task automatic check_all();
    for (int p = 0; p < 2; p++) begin
      chk("rdata_bypass", rdata_a[p*DW +: DW], exp_rd(raddr[p*AW +: AW], 1'b1));
      chk("rdata_nobypass", rdata_b[p*DW +: DW], exp_rd(raddr[p*AW +: AW], 1'b0));
    end
    chk("busy_a", {31'd0, busy_a}, {31'd0, clr_left > 0});
    chk("busy_b", {31'd0, busy_b}, {31'd0, clr_left > 0});
    chk("clr_done_a", {31'd0, done_a}, {31'd0, clr_left == 1});
    chk("clr_done_b", {31'd0, done_b}, {31'd0, clr_left == 1});
    chk("wr_err_a", {31'd0, err_a}, {31'd0, err_m});
    chk("wr_err_b", {31'd0, err_b}, {31'd0, err_m});
    chk("dbg_a", dbg_a, dbg_m);
    chk("dbg_b", dbg_b, dbg_m);
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic c, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                       input logic [AW-1:0] ds);
    we = w; waddr = wa; wdata = wd; clr_req = c; raddr = {r1, r0}; dbg_sel = ds;
    #4;
    check_all();
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          w;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          c;
    logic [AW-1:0] r0, r1;
    logic [DW-1:0] e_r0, e_r1, e_nb0, e_dbg;
    logic          e_busy, e_err;
  } vec_t;

  vec_t vt [7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int done_cnt;

    vt[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
    vt[2] = '{1'b1, 5'd7, 32'h12345678, 1'b0, 5'd7, 5'd5, 32'h12345678, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0};
    vt[3] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd7, 32'h0, 32'h12345678, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0};
    vt[4] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0};
    vt[5] = '{1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd3, 5'd7, 32'h0, 32'h12345678, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0};
    vt[6] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd7, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b1, 1'b1};

    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; clr_req = 1'b0; raddr = '0; dbg_sel = '0;
    model_reset();
    #3;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      drive(vt[i].w, vt[i].wa, vt[i].wd, vt[i].c, vt[i].r0, vt[i].r1, 5'd5);
      chk("tbl_rdata0", rdata_a[DW-1:0], vt[i].e_r0);
      chk("tbl_rdata1", rdata_a[2*DW-1:DW], vt[i].e_r1);
      chk("tbl_nobypass_rdata0", rdata_b[DW-1:0], vt[i].e_nb0);
      chk("tbl_dbg", dbg_a, vt[i].e_dbg);
      chk("tbl_busy", {31'd0, busy_a}, {31'd0, vt[i].e_busy});
      chk("tbl_wr_err", {31'd0, err_a}, {31'd0, vt[i].e_err});
      cycle();
    end
    for (int i = 0; i < 50 && busy_a; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd5, 5'd5);
      cycle();
    end
    chk("drain_busy", {31'd0, busy_a}, 32'd0);

    // Fill r1..r31, sweep, write during CLEAR, then everything reads zero.
    for (int i = 1; i < DEPTH; i++) begin
      drive(1'b1, AW'(i), 32'h10000000 + i * 32'h01010101, 1'b0, AW'(i), AW'(i - 1), AW'(i - 1));
      cycle();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd31, 5'd31);
    cycle();
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      drive(i == 2, 5'd3, 32'hCAFE0003, 1'b0, 5'd3, AW'(i), 5'd3);
      if (i == 3) chk("wr_err_in_clear", {31'd0, err_a}, 32'd1);
      if (busy_a) busy_cnt++;
      if (done_a) done_cnt++;
      if (!busy_a) break;
      cycle();
    end
    chk("sweep_busy_cycles", busy_cnt, 32'd33);
    chk("sweep_done_pulses", done_cnt, 32'd1);
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, AW'(a), AW'(31 - a), AW'(a));
      chk("post_sweep_zero", rdata_a[DW-1:0], 32'h0);
      cycle();
    end

    // Reset at sweep counter 10, then debug-port latency.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd2, 5'd0);
    cycle();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd2, 5'd0);
      cycle();
    end
    we = 1'b0; clr_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_sweep_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_mid_sweep_done", {31'd0, done_a}, 32'd0);
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 5'd4, 32'h0BADF00D, 1'b0, 5'd4, 5'd0, 5'd0);
    cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd4, 5'd4);
    chk("dbg_before_edge", dbg_a, 32'h0);
    cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd4, 5'd4);
    chk("dbg_after_edge", dbg_a, 32'h0BADF00D);
    cycle();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), AW'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 49) == 0, AW'($urandom_range(0, 31)),
            AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
